fb_reader_2to1: RTL and testbench

Two-client framebuffer read port.
- Arbitrates round-robin between two pixel-read request streams.
- Issues single-beat AXI reads to the framebuffer backing memory and routes each returned pixel to the client that requested it.
- Read-side counterpart of the two-client framebuffer write path.
- Sits between display/blit readers and the SRAM AXI slave.

---
 rtl/fb_reader_pkg.sv | 11 +
 rtl/fb_reader_id_fifo.sv | 57 +++++
 rtl/fb_reader_2to1.sv | 131 +++++++++++++
 tb/tb_fb_reader_2to1.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_reader_pkg.sv
// Shared types and constants for the two-client framebuffer read port.
package fb_reader_pkg;

    typedef logic client_id_t;

    localparam client_id_t CLIENT0 = 1'b0;
    localparam client_id_t CLIENT1 = 1'b1;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/fb_reader_id_fifo.sv
// Synchronous FIFO of client IDs, one entry per read issued on AR and not yet returned on R.
module fb_reader_id_fifo
    import fb_reader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  client_id_t               push_id,
    input  logic                     pop,
    output client_id_t               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    client_id_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage has no reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_id;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fb_reader_2to1.sv
// Two-client framebuffer read port: round-robin AR issue, in-order R routing by client ID.
// Define FB_READER_2TO1_ERR_EN to add err_count and zero the color of error beats.
module fb_reader_2to1
    import fb_reader_pkg::*;
#(
    parameter int PIXEL_BITS      = 12,
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in0_axi_tvalid,
    output logic                      in0_axi_tready,
    input  logic [AXI_ADDR_WIDTH-1:0] in0_addr,
    output logic                      out0_axi_tvalid,
    input  logic                      out0_axi_tready,
    output logic [PIXEL_BITS-1:0]     out0_color,
    input  logic                      in1_axi_tvalid,
    output logic                      in1_axi_tready,
    input  logic [AXI_ADDR_WIDTH-1:0] in1_addr,
    output logic                      out1_axi_tvalid,
    input  logic                      out1_axi_tready,
    output logic [PIXEL_BITS-1:0]     out1_color,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready
`ifdef FB_READER_2TO1_ERR_EN
    ,
    output logic [7:0]                err_count
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    client_id_t            last_grant;
    client_id_t            winner;
    client_id_t            head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CNT_W-1:0]      outstanding;
    logic                  slot_free;
    logic                  can_accept;
    logic                  accept;
    logic                  head_ready;
    logic                  r_hs;
    logic [PIXEL_BITS-1:0] beat_color;

    // Gating with reset keeps both treadys low while the block is held in reset.
    assign slot_free  = !axi_arvalid || axi_arready;
    assign can_accept = reset && slot_free && !fifo_full;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        winner = ~last_grant;
        if (in0_axi_tvalid && !in1_axi_tvalid)
            winner = CLIENT0;
        else if (in1_axi_tvalid && !in0_axi_tvalid)
            winner = CLIENT1;
    end

    assign in0_axi_tready = can_accept && (winner == CLIENT0);
    assign in1_axi_tready = can_accept && (winner == CLIENT1);
    assign accept = (in0_axi_tready && in0_axi_tvalid) || (in1_axi_tready && in1_axi_tvalid);

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            axi_arvalid <= 1'b0;
            axi_araddr  <= '0;
            last_grant  <= CLIENT1;
        end else begin
            if (accept) begin
                axi_arvalid <= 1'b1;
                axi_araddr  <= (winner == CLIENT1) ? in1_addr : in0_addr;
                last_grant  <= winner;
            end else if (axi_arready) begin
                axi_arvalid <= 1'b0;
            end
        end
    end

    fb_reader_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (winner),
        .pop     (r_hs),
        .head    (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (outstanding)
    );

    // R is a pure pass-through; the FIFO head names the client owning the current beat.
    assign head_ready = (head == CLIENT1) ? out1_axi_tready : out0_axi_tready;
    assign axi_rready = !fifo_empty && head_ready;
    assign r_hs       = axi_rvalid && axi_rready;

    assign out0_axi_tvalid = axi_rvalid && !fifo_empty && (head == CLIENT0);
    assign out1_axi_tvalid = axi_rvalid && !fifo_empty && (head == CLIENT1);
    assign out0_color = (!fifo_empty && head == CLIENT0) ? beat_color : '0;
    assign out1_color = (!fifo_empty && head == CLIENT1) ? beat_color : '0;

`ifdef FB_READER_2TO1_ERR_EN
    logic beat_err;

    assign beat_err   = (axi_rresp != AXI_RESP_OKAY);
    assign beat_color = beat_err ? '0 : axi_rdata[PIXEL_BITS-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count <= '0;
        else if (r_hs && beat_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`else
    assign beat_color = axi_rdata[PIXEL_BITS-1:0];
`endif

    // Upper data bits, rresp (default build) and the occupancy count are not needed here.
    logic unused_ok;
    assign unused_ok = ^{axi_rdata, axi_rresp, outstanding};

endmodule

// File: tb/tb_fb_reader_2to1.sv
// Randomized scoreboard bench for fb_reader_2to1 against a queue-based transaction model.
module tb_fb_reader_2to1;

    localparam int PB = 12;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int MO = 4;

    typedef struct {
        logic [PB-1:0] color;
        bit            err;
    } exp_pix_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in0_axi_tvalid = 1'b0;
    logic          in1_axi_tvalid = 1'b0;
    logic [AW-1:0] in0_addr = '0;
    logic [AW-1:0] in1_addr = '0;
    logic          in0_axi_tready;
    logic          in1_axi_tready;
    logic          out0_axi_tvalid;
    logic          out1_axi_tvalid;
    logic          out0_axi_tready = 1'b0;
    logic          out1_axi_tready = 1'b0;
    logic [PB-1:0] out0_color;
    logic [PB-1:0] out1_color;
    logic [AW-1:0] axi_araddr;
    logic          axi_arvalid;
    logic          axi_arready = 1'b0;
    logic [DW-1:0] axi_rdata = '0;
    logic [1:0]    axi_rresp = 2'b00;
    logic          axi_rvalid = 1'b0;
    logic          axi_rready;
`ifdef FB_READER_2TO1_ERR_EN
    logic [7:0]    err_count;
`endif

    int checks = 0;
    int errors = 0;

    // Stimulus knobs (percent probabilities) written by the sequencer.
    int p_v0 = 0, p_v1 = 0, p_arr = 0, p_or0 = 0, p_or1 = 0, p_rv = 0;
    bit hold_r = 1'b0;
    bit seq_addr = 1'b1;
    int base0 = 0, base1 = 0, n_acc0 = 0, n_acc1 = 0;

    // Reference model state.
    int            outstanding_m = 0;
    bit            ar_pend_m = 1'b0;
    bit            last_grant_m = 1'b1;
    bit            id_q_m[$];
    logic [AW-1:0] exp_ar_q[$];
    exp_pix_t      exp_pix0[$];
    exp_pix_t      exp_pix1[$];
    logic [AW-1:0] slave_q[$];
    bit            r_active = 1'b0;
    int            err_exp = 0;

    always #5 clk = ~clk;

    fb_reader_2to1 #(
        .PIXEL_BITS      (PB),
        .AXI_ADDR_WIDTH  (AW),
        .AXI_DATA_WIDTH  (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in0_axi_tvalid  (in0_axi_tvalid),
        .in0_axi_tready  (in0_axi_tready),
        .in0_addr        (in0_addr),
        .out0_axi_tvalid (out0_axi_tvalid),
        .out0_axi_tready (out0_axi_tready),
        .out0_color      (out0_color),
        .in1_axi_tvalid  (in1_axi_tvalid),
        .in1_axi_tready  (in1_axi_tready),
        .in1_addr        (in1_addr),
        .out1_axi_tvalid (out1_axi_tvalid),
        .out1_axi_tready (out1_axi_tready),
        .out1_color      (out1_color),
        .axi_araddr      (axi_araddr),
        .axi_arvalid     (axi_arvalid),
        .axi_arready     (axi_arready),
        .axi_rdata       (axi_rdata),
        .axi_rresp       (axi_rresp),
        .axi_rvalid      (axi_rvalid),
        .axi_rready      (axi_rready)
`ifdef FB_READER_2TO1_ERR_EN
        ,
        .err_count       (err_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected-event expected=none at %0t", name, $time);
    endtask

    // Backing memory contents and response code are pure functions of the address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h0AAC;
    endfunction

    function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
        return (a[3:0] == 4'hF) ? 2'b10 : 2'b00;
    endfunction

    function automatic exp_pix_t expect_pix(input logic [AW-1:0] a);
        exp_pix_t      e;
        logic [DW-1:0] w;
        w       = mem_word(a);
        e.color = w[PB-1:0];
        e.err   = (resp_of(a) != 2'b00);
`ifdef FB_READER_2TO1_ERR_EN
        if (e.err)
            e.color = '0;
`endif
        return e;
    endfunction

    function automatic bit rnd(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    // Driver, AXI slave and transaction-level model: pushes expectations on acceptance.
    initial begin : model
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                in0_axi_tvalid = 1'b0;
                in1_axi_tvalid = 1'b0;
                axi_rvalid     = 1'b0;
                continue;
            end
            in0_axi_tvalid  = rnd(p_v0);
            in1_axi_tvalid  = rnd(p_v1);
            in0_addr        = seq_addr ? AW'(base0 + n_acc0) : AW'($urandom);
            in1_addr        = seq_addr ? AW'(base1 + n_acc1) : AW'($urandom);
            axi_arready     = rnd(p_arr);
            out0_axi_tready = rnd(p_or0);
            out1_axi_tready = rnd(p_or1);
            if (!r_active && slave_q.size() > 0 && !hold_r && rnd(p_rv)) begin
                r_active  = 1'b1;
                axi_rdata = mem_word(slave_q[0]);
                axi_rresp = resp_of(slave_q[0]);
            end
            axi_rvalid = r_active;

            @(negedge clk);
            if (!reset)
                continue;
            begin
                bit v0, v1, can, win, has, head, exp_rready, accept, r_hs;
                v0  = in0_axi_tvalid;
                v1  = in1_axi_tvalid;
                can = (!ar_pend_m || axi_arready) && (outstanding_m < MO);
                if (v0 && v1)
                    win = !last_grant_m;
                else
                    win = v1;
                if (v0 || v1) begin
                    check("tready0", 32'(in0_axi_tready), 32'(can && !win));
                    check("tready1", 32'(in1_axi_tready), 32'(can && win));
                end else begin
                    check("tready_idle", 32'(in0_axi_tready) + 32'(in1_axi_tready), 32'(can));
                end
                check("arvalid", 32'(axi_arvalid), 32'(ar_pend_m));

                has  = (id_q_m.size() > 0);
                head = has ? id_q_m[0] : 1'b0;
                exp_rready = has && (head ? out1_axi_tready : out0_axi_tready);
                check("rready", 32'(axi_rready), 32'(exp_rready));
                check("out_tvalid", {30'd0, out1_axi_tvalid, out0_axi_tvalid},
                      {30'd0, axi_rvalid && has && head, axi_rvalid && has && !head});
                if (!has)
                    check("idle_color", {8'd0, out1_color, out0_color}, 32'd0);
                else
                    check("idle_color", 32'(head ? out0_color : out1_color), 32'd0);

                accept = (v0 || v1) && can;
                r_hs   = axi_rvalid && exp_rready;
                if (axi_arvalid && axi_arready)
                    slave_q.push_back(axi_araddr);
                if (axi_rvalid && axi_rready) begin
                    if (slave_q.size() > 0)
                        void'(slave_q.pop_front());
                    r_active = 1'b0;
                end
                if (accept) begin
                    logic [AW-1:0] a;
                    a = win ? in1_addr : in0_addr;
                    exp_ar_q.push_back(a);
                    if (win) begin
                        exp_pix1.push_back(expect_pix(a));
                        n_acc1++;
                    end else begin
                        exp_pix0.push_back(expect_pix(a));
                        n_acc0++;
                    end
                    id_q_m.push_back(win);
                    last_grant_m = win;
                end
                if (r_hs)
                    void'(id_q_m.pop_front());
                outstanding_m = outstanding_m + int'(accept) - int'(r_hs);
                ar_pend_m = accept ? 1'b1 : (axi_arready ? 1'b0 : ar_pend_m);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes an AR or pixel handshake.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset)
                continue;
`ifdef FB_READER_2TO1_ERR_EN
            check("err_count", 32'(err_count), 32'(err_exp));
`endif
            if (axi_arvalid && axi_arready) begin
                if (exp_ar_q.size() == 0)
                    flag_fail("araddr_unexpected");
                else
                    check("araddr", 32'(axi_araddr), 32'(exp_ar_q.pop_front()));
            end
            if (out0_axi_tvalid && out0_axi_tready) begin
                if (exp_pix0.size() == 0) begin
                    flag_fail("out0_unexpected");
                end else begin
                    exp_pix_t e;
                    e = exp_pix0.pop_front();
                    check("out0_color", 32'(out0_color), 32'(e.color));
                    if (e.err && err_exp < 255)
                        err_exp++;
                end
            end
            if (out1_axi_tvalid && out1_axi_tready) begin
                if (exp_pix1.size() == 0) begin
                    flag_fail("out1_unexpected");
                end else begin
                    exp_pix_t e;
                    e = exp_pix1.pop_front();
                    check("out1_color", 32'(out1_color), 32'(e.color));
                    if (e.err && err_exp < 255)
                        err_exp++;
                end
            end
        end
    end

    task automatic knobs(input int v0, input int v1, input int arr,
                         input int or0, input int or1, input int rv);
        p_v0 = v0; p_v1 = v1; p_arr = arr; p_or0 = or0; p_or1 = or1; p_rv = rv;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tready"}, {30'd0, in1_axi_tready, in0_axi_tready}, 32'd0);
        check({tag, "_tvalid"}, {30'd0, out1_axi_tvalid, out0_axi_tvalid}, 32'd0);
        check({tag, "_arvalid"}, 32'(axi_arvalid), 32'd0);
        check({tag, "_araddr"}, 32'(axi_araddr), 32'd0);
        check({tag, "_rready"}, 32'(axi_rready), 32'd0);
    endtask

    task automatic clear_model();
        outstanding_m = 0;
        ar_pend_m     = 1'b0;
        last_grant_m  = 1'b1;
        r_active      = 1'b0;
        err_exp       = 0;
        id_q_m.delete();
        exp_ar_q.delete();
        exp_pix0.delete();
        exp_pix1.delete();
        slave_q.delete();
    endtask

    task automatic drain(input string tag);
        int busy;
        knobs(0, 0, 100, 100, 100, 100);
        hold_r = 1'b0;
        busy = 1;
        for (int i = 0; i < 300 && busy != 0; i++) begin
            @(posedge clk);
            busy = exp_pix0.size() + exp_pix1.size() + exp_ar_q.size();
        end
        check({tag, "_drained"}, 32'(busy), 32'd0);
    endtask

    task automatic start_seq(input int b0, input int b1);
        seq_addr = 1'b1;
        base0 = b0; base1 = b1; n_acc0 = 0; n_acc1 = 0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : sequencer
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(posedge clk);
        #3 reset = 1'b1;

        // Contention: both clients always valid, client 0 wins first after reset.
        start_seq(32'h100, 32'h200);
        @(posedge clk);
        knobs(100, 100, 100, 100, 100, 100);
        repeat (20) @(posedge clk);
        drain("contention");

        // Single read from client 0.
        start_seq(32'h00010, 32'h0);
        knobs(100, 0, 100, 100, 100, 100);
        @(posedge clk);
        p_v0 = 0;
        repeat (6) @(posedge clk);
        drain("single");

        // AR backpressure then release.
        start_seq(32'h300, 32'h400);
        knobs(100, 100, 0, 100, 100, 100);
        repeat (5) @(posedge clk);
        p_arr = 100;
        repeat (10) @(posedge clk);
        drain("ar_bp");

        // Outstanding limit: R withheld, then released.
        start_seq(32'h500, 32'h600);
        hold_r = 1'b1;
        knobs(100, 100, 100, 100, 100, 100);
        repeat (12) @(posedge clk);
        hold_r = 1'b0;
        repeat (10) @(posedge clk);
        drain("limit");

        // R backpressure on client 1 only.
        start_seq(32'h700, 32'h800);
        knobs(100, 100, 100, 100, 0, 100);
        repeat (15) @(posedge clk);
        p_or1 = 100;
        repeat (5) @(posedge clk);
        drain("r_bp");

        // Randomized traffic.
        seq_addr = 1'b0;
        knobs(60, 60, 70, 75, 75, 70);
        repeat (1500) @(posedge clk);
        drain("random");

        // Reset with three reads in flight.
        start_seq(32'h900, 32'hA00);
        hold_r = 1'b1;
        knobs(100, 100, 100, 100, 100, 100);
        for (int i = 0; i < 50 && outstanding_m != 3; i++)
            @(posedge clk);
        knobs(0, 0, 100, 100, 100, 100);
        check("reach_outstanding_3", 32'(outstanding_m), 32'd3);
        #3 reset = 1'b0;
        #1;
        check_idle("midreset");
        clear_model();
        hold_r = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        start_seq(32'hB00, 32'hC00);
        @(posedge clk);
        knobs(100, 100, 100, 100, 100, 100);
        @(posedge clk);
        knobs(0, 0, 100, 100, 100, 100);
        drain("post_reset");

        // Error-response beat from client 0.
        start_seq(32'h0001F, 32'h0);
        knobs(100, 0, 100, 100, 100, 100);
        @(posedge clk);
        p_v0 = 0;
        drain("err_beat");
`ifdef FB_READER_2TO1_ERR_EN
        #1;
        check("err_count_final", 32'(err_count), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
